// File: rtl/host_ctrl_stream_if.sv
// Generic valid/ready beat stream used for the memory word input and the
// host RX/TX byte streams of host_ctrl_stream. W sets the data width.
interface host_ctrl_stream_if #(
  parameter int W = 8
) ();
  logic         tvalid;
  logic [W-1:0] tdata;
  logic         tready;

  modport master (output tvalid, output tdata, input tready);
  modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/host_ctrl_stream.sv
// host_ctrl_stream: host-side command parser and memory-word serialiser.
//   RX: host beats -> short (code only) or long (code + CDW/HDW beats) commands.
//   TX: MDW memory words or the ID word -> HDW beats, LSB beat first,
//       paused at word boundaries while the host has sent XOFF.
// Optional build macro CTRL_TIMEOUT_EN: abandon a long command after TMO
// idle cycles inside its data phase. Without it the data phase waits forever.
module host_ctrl_stream #(
  parameter int             MDW = 32,
  parameter int             HDW = 8,
  parameter int             CDW = 32,
  parameter logic [CDW-1:0] ID  = 32'h534c4131,
  parameter int             TMO = 1024
) (
  input  logic               clk,
  input  logic               rst,
  host_ctrl_stream_if.slave  mem,
  host_ctrl_stream_if.slave  str_rxd,
  host_ctrl_stream_if.master str_txd,
  output logic [7:0]         ctl_code,
  output logic [CDW-1:0]     ctl_data,
  output logic               ctl_valid,
  output logic               ctl_xoff
);

  localparam int NDB = CDW / HDW;
  localparam int MNB = MDW / HDW;
  localparam int SW  = (MDW > CDW) ? MDW : CDW;
  localparam int TNB = SW / HDW;
  localparam int TCW = $clog2(TNB + 1);
  localparam int RCW = $clog2(NDB + 1);

  localparam logic [TCW-1:0] MEM_LAST = TCW'(MNB - 1);
  localparam logic [TCW-1:0] ID_LAST  = TCW'(NDB - 1);
  localparam logic [RCW-1:0] RX_LAST  = RCW'(NDB - 1);

  localparam logic [0:0] RX_IDLE = 1'b0;
  localparam logic [0:0] RX_DATA = 1'b1;

  localparam logic [1:0] TX_IDLE = 2'd0;
  localparam logic [1:0] TX_MEM  = 2'd1;
  localparam logic [1:0] TX_ID   = 2'd2;

  // RX parser state
  logic [0:0]     rx_state_q, rx_state_d;
  logic [RCW-1:0] rx_cnt_q, rx_cnt_d;
  logic [7:0]     ctl_code_q, ctl_code_d;
  logic [CDW-1:0] ctl_data_q, ctl_data_d;
  logic           ctl_valid_q, ctl_valid_d;
  logic           ctl_xoff_q, ctl_xoff_d;
  logic           id_req_q, id_req_d;

  // TX serialiser state
  logic [1:0]     tx_state_q, tx_state_d;
  logic [SW-1:0]  tx_sh_q, tx_sh_d;
  logic [TCW-1:0] tx_cnt_q, tx_cnt_d;
  logic           tx_valid_q, tx_valid_d;

  logic rx_xfer_s;
  logic tx_xfer_s;
  logic tmo_hit_s;
  logic id_set_s;
  logic id_clr_s;
  logic mem_tready_s;

  assign rx_xfer_s = str_rxd.tvalid;   // parser is always ready
  assign tx_xfer_s = tx_valid_q & str_txd.tready;

`ifdef CTRL_TIMEOUT_EN
  localparam int             TTW      = $clog2(TMO + 1);
  localparam logic [TTW-1:0] TMO_LAST = TTW'(TMO - 1);

  logic [TTW-1:0] tmo_cnt_q, tmo_cnt_d;

  // Idle-cycle counter: runs only in the data phase, cleared by every RX beat
  always_comb begin
    if (rx_state_q != RX_DATA) begin
      tmo_cnt_d = '0;
    end else if (rx_xfer_s) begin
      tmo_cnt_d = '0;
    end else if (tmo_cnt_q == TMO_LAST) begin
      tmo_cnt_d = '0;
    end else begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end
  end

  assign tmo_hit_s = (rx_state_q == RX_DATA) && !rx_xfer_s && (tmo_cnt_q == TMO_LAST);

  // Timeout counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  assign tmo_hit_s = 1'b0;
`endif

  // Command parser: latch code, collect data beats, strobe on completion
  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    ctl_code_d  = ctl_code_q;
    ctl_data_d  = ctl_data_q;
    ctl_valid_d = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_xfer_s) begin
          ctl_code_d = str_rxd.tdata[7:0];
          rx_cnt_d   = '0;
          if (str_rxd.tdata[7]) begin
            rx_state_d = RX_DATA;
          end else begin
            ctl_data_d  = '0;
            ctl_valid_d = 1'b1;
          end
        end else begin
          rx_state_d = RX_IDLE;
        end
      end
      RX_DATA: begin
        if (rx_xfer_s) begin
          ctl_data_d[rx_cnt_q*HDW +: HDW] = str_rxd.tdata;
          if (rx_cnt_q == RX_LAST) begin
            ctl_valid_d = 1'b1;
            rx_state_d  = RX_IDLE;
          end else begin
            rx_cnt_d = rx_cnt_q + 1'b1;
          end
        end else if (tmo_hit_s) begin
          rx_state_d = RX_IDLE;
        end else begin
          rx_state_d = RX_DATA;
        end
      end
      default: begin
        rx_state_d = RX_IDLE;
      end
    endcase
  end

  // Act on completed commands: flow control and ID request
  always_comb begin
    ctl_xoff_d = ctl_xoff_q;
    id_set_s   = 1'b0;
    if (ctl_valid_q) begin
      case (ctl_code_q)
        8'h11:   ctl_xoff_d = 1'b0;
        8'h13:   ctl_xoff_d = 1'b1;
        8'h02:   id_set_s   = 1'b1;
        default: ctl_xoff_d = ctl_xoff_q;
      endcase
    end else begin
      ctl_xoff_d = ctl_xoff_q;
    end
    id_req_d = (id_req_q & ~id_clr_s) | id_set_s;
  end

  // TX serialiser: pick ID or memory word at a word boundary, shift out beats
  always_comb begin
    tx_state_d   = tx_state_q;
    tx_sh_d      = tx_sh_q;
    tx_cnt_d     = tx_cnt_q;
    tx_valid_d   = tx_valid_q;
    mem_tready_s = 1'b0;
    id_clr_s     = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        if (id_req_q) begin
          tx_sh_d          = '0;
          tx_sh_d[CDW-1:0] = ID;
          tx_cnt_d         = ID_LAST;
          tx_valid_d       = 1'b1;
          tx_state_d       = TX_ID;
          id_clr_s         = 1'b1;
        end else if (mem.tvalid && !ctl_xoff_q) begin
          mem_tready_s     = 1'b1;
          tx_sh_d          = '0;
          tx_sh_d[MDW-1:0] = mem.tdata;
          tx_cnt_d         = MEM_LAST;
          tx_valid_d       = 1'b1;
          tx_state_d       = TX_MEM;
        end else begin
          tx_valid_d = 1'b0;
        end
      end
      TX_MEM, TX_ID: begin
        if (tx_xfer_s) begin
          if (tx_cnt_q == '0) begin
            tx_valid_d = 1'b0;
            tx_state_d = TX_IDLE;
          end else begin
            tx_sh_d  = tx_sh_q >> HDW;
            tx_cnt_d = tx_cnt_q - 1'b1;
          end
        end else begin
          tx_valid_d = 1'b1;
        end
      end
      default: begin
        tx_valid_d = 1'b0;
        tx_state_d = TX_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state_q  <= RX_IDLE;
      rx_cnt_q    <= '0;
      ctl_code_q  <= 8'h00;
      ctl_data_q  <= '0;
      ctl_valid_q <= 1'b0;
      ctl_xoff_q  <= 1'b0;
      id_req_q    <= 1'b0;
      tx_state_q  <= TX_IDLE;
      tx_sh_q     <= '0;
      tx_cnt_q    <= '0;
      tx_valid_q  <= 1'b0;
    end else begin
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      ctl_code_q  <= ctl_code_d;
      ctl_data_q  <= ctl_data_d;
      ctl_valid_q <= ctl_valid_d;
      ctl_xoff_q  <= ctl_xoff_d;
      id_req_q    <= id_req_d;
      tx_state_q  <= tx_state_d;
      tx_sh_q     <= tx_sh_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_valid_q  <= tx_valid_d;
    end
  end

  // Word acceptance is combinational and never offered while reset is held
  assign mem.tready     = mem_tready_s & ~rst;
  assign str_rxd.tready = 1'b1;
  assign str_txd.tvalid = tx_valid_q;
  assign str_txd.tdata  = tx_sh_q[HDW-1:0];
  assign ctl_code       = ctl_code_q;
  assign ctl_data       = ctl_data_q;
  assign ctl_valid      = ctl_valid_q;
  assign ctl_xoff       = ctl_xoff_q;

endmodule
